// File: rtl/mdu_pkg.sv
// Shared op-code and FSM encodings for the multiply/divide unit.
// Op codes not listed here decode as no-op in mul_div_unit.
package mdu_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational; requires i_rem < i_dvs for a valid quotient bit.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  // Top bit of the difference is the borrow: set means the divisor did not fit.
  assign o_q     = ~w_diff[WIDTH];
  assign o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: MUL_LAT-cycle multiply, WIDTH+1-cycle restoring divide, 1-edge mthi/mtlo.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu accumulate ops; otherwise they decode as no-op.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2((MUL_LAT > WIDTH) ? MUL_LAT : WIDTH) + 1;

  mdu_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [WIDTH-1:0]   r_rem, r_quo, r_dvs;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_busy;

  logic               w_op_mul, w_op_div;
  logic               w_accept, w_mul_done, w_div_step, w_fix, w_mthi, w_mtlo;
  logic               w_sgn, w_neg_q, w_neg_r, w_qbit;
  logic [WIDTH-1:0]   w_rem_nxt, w_quo_fix, w_rem_fix;
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod, w_mul_res;

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

`ifdef MDU_MADD_EN
  assign w_op_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                    (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
  assign w_op_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
  assign w_op_div = (op == OP_DIV) || (op == OP_DIVU);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Cancel beats both a fresh start and an op that is about to complete.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mul_done  = 1'b0;
    w_div_step  = 1'b0;
    w_fix       = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (w_op_mul) begin
            w_state_nxt = ST_MUL;
            w_accept    = 1'b1;
          end else if (w_op_div) begin
            w_state_nxt = ST_DIV;
            w_accept    = 1'b1;
          end else if (op == OP_MTHI) begin
            w_mthi = 1'b1;
          end else if (op == OP_MTLO) begin
            w_mtlo = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_mul_done  = 1'b1;
        end
      end
      ST_DIV: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_div_step = 1'b1;
          if (r_cnt == '0) w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        w_fix       = !cancel;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sign-extending to 2*WIDTH makes one multiplier serve both signed and unsigned ops.
  assign w_sgn   = op_is_signed(r_op);
  assign w_a_ext = {{WIDTH{w_sgn & r_a[WIDTH-1]}}, r_a};
  assign w_b_ext = {{WIDTH{w_sgn & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

`ifdef MDU_MADD_EN
  always_comb begin
    w_mul_res = w_prod;
    if ((r_op == OP_MADD) || (r_op == OP_MADDU))      w_mul_res = {r_hi, r_lo} + w_prod;
    else if ((r_op == OP_MSUB) || (r_op == OP_MSUBU)) w_mul_res = {r_hi, r_lo} - w_prod;
  end
`else
  assign w_mul_res = w_prod;
`endif

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_rem),
    .i_bit (r_quo[WIDTH-1]),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_q   (w_qbit)
  );

  assign w_neg_q   = w_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
  assign w_neg_r   = w_sgn & r_a[WIDTH-1];
  assign w_quo_fix = w_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = w_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        r_op  <= op;
        r_a   <= A;
        r_b   <= B;
        r_rem <= '0;
        r_quo <= (op_is_signed(op) && A[WIDTH-1]) ? -A : A;
        r_dvs <= (op_is_signed(op) && B[WIDTH-1]) ? -B : B;
        r_cnt <= w_op_mul ? CNT_W'(MUL_LAT - 1) : CNT_W'(WIDTH - 1);
      end else if ((r_state == ST_MUL || r_state == ST_DIV) && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_div_step) begin
        r_rem <= w_rem_nxt;
        r_quo <= {r_quo[WIDTH-2:0], w_qbit};
      end
      if (w_mthi) r_hi <= A;
      if (w_mtlo) r_lo <= A;
      if (w_mul_done) {r_hi, r_lo} <= w_mul_res;
      if (w_fix) begin
        if (r_b == '0) begin
          r_lo <= '1;
          r_hi <= r_a;
        end else begin
          r_lo <= w_quo_fix;
          r_hi <= w_rem_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit (WIDTH=32, MUL_LAT=5): vector table plus busy/cancel/reset/accumulate sequences.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op, scramble the inputs while busy, and count busy cycles (bounded).
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 4'hF; A = ~a; B = b ^ 32'h5A5A5A5A;
    lat = 0;
    while (busy && lat < 200) begin
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{OP_MULT,  32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 5};
    vecs[3]  = '{OP_MULT,  32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 5};
    vecs[4]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[6]  = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        33};
    vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[8]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[9]  = '{OP_DIVU,  32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 33};
    vecs[10] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33};
    vecs[12] = '{OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 33};
    vecs[13] = '{OP_MTHI,  32'hDEADBEEF, 32'd9,        32'hDEADBEEF, 32'hFFFFFFFF, 0};
    vecs[14] = '{OP_MTLO,  32'd5,        32'd9,        32'hDEADBEEF, 32'd5,        0};
    vecs[15] = '{4'hF,     32'd1,        32'd1,        32'hDEADBEEF, 32'd5,        0};

    #3 reset_n = 1'b0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
    end

    // Second start while a multiply is in flight must be ignored.
    run_op(OP_MTLO, 32'd5, 32'd0, lat);
    @(negedge clk); start = 1'b1; op = OP_MULT; A = 32'd3; B = 32'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
    @(negedge clk); start = 1'b0;
    check("ignore_mid_busy", {31'd0, busy}, 32'd1);
    check("ignore_mid_lo", LO, 32'd5);
    lat = 0;
    while (busy && lat < 200) begin lat++; @(negedge clk); end
    check("ignore_rest_lat", lat, 32'd3);
    check("ignore_lo", LO, 32'd12);
    check("ignore_hi", HI, 32'd0);
    @(negedge clk);
    check("ignore_no_div", {31'd0, busy}, 32'd0);

    // Cancel at cycle 10 of a divide.
    run_op(OP_MTHI, 32'hAAAA, 32'd0, lat);
    run_op(OP_MTLO, 32'hBBBB, 32'd0, lat);
    @(negedge clk); start = 1'b1; op = OP_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    check("cancel_pre_busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_hi", HI, 32'hAAAA);
    check("cancel_lo", LO, 32'hBBBB);
    repeat (40) @(negedge clk);
    check("cancel_hi_late", HI, 32'hAAAA);

    // Start and cancel together while idle: nothing sampled.
    @(negedge clk); start = 1'b1; cancel = 1'b1; op = OP_MTHI; A = 32'h1111;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    check("startcancel_hi", HI, 32'hAAAA);
    @(negedge clk); start = 1'b1; cancel = 1'b1; op = OP_DIV; A = 32'd9; B = 32'd3;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    check("startcancel_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk); start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("rstmid_pre_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_hi", HI, 32'd0);
    check("rstmid_lo", LO, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    run_op(OP_DIVU, 32'd100, 32'd7, lat);
    check("postrst_lat", lat, 32'd33);
    check("postrst_lo", LO, 32'd14);
    check("postrst_hi", HI, 32'd2);

    // Accumulate ops.
    run_op(OP_MTHI, 32'd0, 32'd0, lat);
    run_op(OP_MTLO, 32'hFFFFFFFF, 32'd0, lat);
    run_op(OP_MADDU, 32'd1, 32'd1, lat);
`ifdef MDU_MADD_EN
    check("maddu_lat", lat, 32'd5);
    check("maddu_hi", HI, 32'd1);
    check("maddu_lo", LO, 32'd0);
    run_op(OP_MSUB, 32'd1, 32'd1, lat);
    check("msub_lat", lat, 32'd5);
    check("msub_hi", HI, 32'd0);
    check("msub_lo", LO, 32'hFFFFFFFF);
`else
    check("maddu_lat", lat, 32'd0);
    check("maddu_hi", HI, 32'd0);
    check("maddu_lo", LO, 32'hFFFFFFFF);
    run_op(OP_MSUB, 32'd1, 32'd1, lat);
    check("msub_lat", lat, 32'd0);
    check("msub_lo", LO, 32'hFFFFFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width (>=8, even).
REQ-002 SHALL have parameter MUL_LAT, default 5, multiply busy cycles (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request, qualified by op.
REQ-006 SHALL have port op  input  4  mult, multu, div, divu, mthi, mtlo, madd, maddu, msub, msubu.
REQ-007 SHALL have port A  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data).
REQ-008 SHALL have port B  input  WIDTH  rt operand (divisor / multiplier).
REQ-009 SHALL have port cancel  input  1  pipeline flush; abandons an in-flight op.
REQ-010 SHALL have port busy  output  1  registered; high while an op is in flight.
REQ-011 SHALL have port HI  output  WIDTH  registered HI.
REQ-012 SHALL have port LO  output  WIDTH  registered LO.

Function
REQ-013 SHALL sample start/op/A/B on the rising edge where start=1 and busy=0; start while busy=1 SHALL be ignored.
REQ-014 SHALL implement FSM IDLE, MUL, DIV, FIX; IDLE->MUL on mult-class start; IDLE->DIV on div/divu start; MUL->IDLE after MUL_LAT cycles; DIV->FIX after WIDTH cycles; FIX->IDLE after 1 cycle.
REQ-015 SHALL complete mthi/mtlo in one edge: HI (resp. LO) = A at the sampling edge, busy stays 0.
REQ-016 SHALL raise busy from the edge after sampling; busy falls on the same edge that writes HI/LO.
REQ-017 SHALL give mult/multu total latency MUL_LAT cycles: {HI,LO} = A*B, full 2*WIDTH product, signed or unsigned.
REQ-018 SHALL give div/divu total latency WIDTH+1 cycles: restoring division, one quotient bit per DIV cycle, sign correction in FIX.
REQ-019 SHALL set LO=quotient, HI=remainder; signed: quotient truncates toward zero, remainder takes dividend sign.
REQ-020 SHALL on divide-by-zero set LO = all ones and HI = dividend, with the same latency.
REQ-021 SHALL on signed most-negative / -1 set LO = most-negative and HI = 0.
REQ-022 SHALL leave HI/LO unchanged until the completing edge; intermediates live in internal registers only.
REQ-023 SHALL on cancel=1 with busy=1 return to IDLE next edge, busy=0, HI/LO untouched.
REQ-024 SHALL treat start and cancel asserted together while busy=0 as cancel winning: nothing sampled.
REQ-025 SHALL latch operands so that changes on A/B/op while busy have no effect.
REQ-026 SHALL decode unknown op codes as no-op: no state change, busy stays 0.

Reset
REQ-027 SHALL on reset_n=0 immediately set FSM=IDLE, busy=0, HI=0, LO=0, and clear counter and internal accumulators, independent of clk.
REQ-028 SHALL abandon any in-flight op on reset mid-operation; first usable start is the first edge after reset_n rises.

Configuration
REQ-029 SHALL with MDU_MADD_EN defined support madd/maddu/msub/msubu: {HI,LO} = {HI,LO} +/- A*B (2*WIDTH wrap-around), latency MUL_LAT.
REQ-030 SHALL with MDU_MADD_EN undefined decode madd/maddu/msub/msubu as no-op per REQ-026, with no accumulate adder synthesised.

Structure
REQ-031 SHALL place op encodings (4-bit localparams) and FSM state encodings in shared package mdu_pkg, alongside the existing ALU op header.
REQ-032 SHALL use one sub-module, mdu_div_step (combinational one-bit restoring step: partial remainder, divisor -> next remainder, quotient bit).
REQ-033 SHALL use a log2(max(MUL_LAT,WIDTH))+1 bit down-counter shared by MUL and DIV.

Verification
REQ-034 SHALL cover: mult A=0xFFFFFFFF, B=2 (WIDTH=32) -> after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 SHALL cover: div A=-7, B=2 -> busy 33 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu A=7, B=2 -> LO=3, HI=1.
REQ-036 SHALL cover: divu A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234; div A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
REQ-037 SHALL cover: mtlo A=5 then mult start while busy, with second start at cycle 2 -> second start ignored, LO=5 until first op completes.
REQ-038 SHALL cover: div start, cancel at cycle 10 -> busy=0 next edge, HI/LO keep prior values; reset_n low mid-div -> HI=LO=0 asynchronously.
REQ-039 SHALL cover: with MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> HI=1, LO=0; without macro -> no-op, busy=0.
